// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared opcode, condition and flag constants for the ARM-subset datapath
package arm_pkg;

  // Data-processing opcodes (ARM encoding order)
  localparam logic [4:0] OP_AND    = 5'd0;
  localparam logic [4:0] OP_EOR    = 5'd1;
  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_RSB    = 5'd3;
  localparam logic [4:0] OP_ADD    = 5'd4;
  localparam logic [4:0] OP_ADC    = 5'd5;
  localparam logic [4:0] OP_SBC    = 5'd6;
  localparam logic [4:0] OP_RSC    = 5'd7;
  localparam logic [4:0] OP_TST    = 5'd8;
  localparam logic [4:0] OP_TEQ    = 5'd9;
  localparam logic [4:0] OP_CMP    = 5'd10;
  localparam logic [4:0] OP_CMN    = 5'd11;
  localparam logic [4:0] OP_ORR    = 5'd12;
  localparam logic [4:0] OP_MOV    = 5'd13;
  localparam logic [4:0] OP_BIC    = 5'd14;
  localparam logic [4:0] OP_MVN    = 5'd15;

  // Address-arithmetic opcodes; these never touch the flags
  localparam logic [4:0] OP_PASSB  = 5'd16;
  localparam logic [4:0] OP_SUBAB  = 5'd17;
  localparam logic [4:0] OP_INCB4  = 5'd18;
  localparam logic [4:0] OP_ADDAB  = 5'd19;
  localparam logic [4:0] OP_PASSA  = 5'd20;
  localparam logic [4:0] OP_INCB4M = 5'd21;
  localparam logic [4:0] OP_DECB4  = 5'd22;
  localparam logic [4:0] OP_INCA4  = 5'd23;

  // Condition field codes
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  // Bit positions inside the {C,Z,V,N} flag vector
  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

endpackage

// File: rtl/reg32_en.sv
// rtl/reg32_en.sv - 32-bit load-enabled register with asynchronous active-low clear
module reg32_en (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  // Capture on enabled rising edge; clear immediately when reset drops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 32'h0000_0000;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU, condition tester and result register of the execution core
module alu_exec_unit
  import arm_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        CIN,
  input  logic [4:0]  OP,
  input  logic [3:0]  FLAGS_IN,
  input  logic [3:0]  COND,
  input  logic        LD,
  output logic [31:0] ALU_OUT,
  output logic [3:0]  FLAGS,
  output logic        COND_TRUE,
  output logic [31:0] REG_Q
);

  // Effective adder operands; every arithmetic op is x + y + c
  logic [31:0] w_x;
  logic [31:0] w_y;
  logic        w_c;
  logic        w_arith;
  logic        w_ext;
  logic [31:0] w_other;
  logic [32:0] w_sum;
  logic [31:0] w_t;

  // Decode opcode into adder operands, or a non-adder result
  always_comb begin
    w_x     = A;
    w_y     = B;
    w_c     = 1'b0;
    w_arith = 1'b0;
    w_ext   = 1'b0;
    w_other = 32'h0000_0000;
    case (OP)
      OP_AND, OP_TST: w_other = A & B;
      OP_EOR, OP_TEQ: w_other = A ^ B;
      OP_SUB, OP_CMP: begin
        w_arith = 1'b1;
        w_y     = ~B;
        w_c     = 1'b1;
      end
      OP_RSB: begin
        w_arith = 1'b1;
        w_x     = B;
        w_y     = ~A;
        w_c     = 1'b1;
      end
      OP_ADD, OP_CMN: w_arith = 1'b1;
      OP_ADC: begin
        w_arith = 1'b1;
        w_c     = CIN;
      end
      OP_SBC: begin
        w_arith = 1'b1;
        w_y     = ~B;
        w_c     = CIN;
      end
      OP_RSC: begin
        w_arith = 1'b1;
        w_x     = B;
        w_y     = ~A;
        w_c     = CIN;
      end
      OP_ORR: w_other = A | B;
      OP_MOV: w_other = B;
      OP_BIC: w_other = A & ~B;
      OP_MVN: w_other = ~B;
      OP_PASSB: begin
        w_ext   = 1'b1;
        w_other = B;
      end
      OP_SUBAB: begin
        w_ext   = 1'b1;
        w_other = A - B;
      end
      OP_INCB4, OP_INCB4M: begin
        w_ext   = 1'b1;
        w_other = B + 32'd4;
      end
      OP_ADDAB: begin
        w_ext   = 1'b1;
        w_other = A + B;
      end
      OP_PASSA: begin
        w_ext   = 1'b1;
        w_other = A;
      end
      OP_DECB4: begin
        w_ext   = 1'b1;
        w_other = B - 32'd4;
      end
      OP_INCA4: begin
        w_ext   = 1'b1;
        w_other = A + 32'd4;
      end
      default: begin
        w_ext   = 1'b1;
        w_other = 32'h0000_0000;
      end
    endcase
  end

  // 33-bit sum so bit 32 carries out as C (not-borrow for subtracts)
  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'h0000_0000, w_c};
  assign w_t   = w_arith ? w_sum[31:0] : w_other;

  assign ALU_OUT = w_t;

  // Flag generation: address ops pass flags through, logic ops keep V and take C from CIN
  always_comb begin
    FLAGS = FLAGS_IN;
    if (!w_ext) begin
      FLAGS[FLG_Z] = (w_t == 32'h0000_0000);
      FLAGS[FLG_N] = w_t[31];
      if (w_arith) begin
        FLAGS[FLG_C] = w_sum[32];
        FLAGS[FLG_V] = (w_x[31] == w_y[31]) && (w_t[31] != w_x[31]);
      end else begin
        FLAGS[FLG_C] = CIN;
        FLAGS[FLG_V] = FLAGS_IN[FLG_V];
      end
    end
  end

  // Condition test against the current (incoming) flags
  always_comb begin
    COND_TRUE = 1'b1;
    case (COND)
      COND_EQ: COND_TRUE = FLAGS_IN[FLG_Z];
      COND_NE: COND_TRUE = !FLAGS_IN[FLG_Z];
      COND_CS: COND_TRUE = FLAGS_IN[FLG_C];
      COND_CC: COND_TRUE = !FLAGS_IN[FLG_C];
      COND_MI: COND_TRUE = FLAGS_IN[FLG_N];
      COND_PL: COND_TRUE = !FLAGS_IN[FLG_N];
      COND_VS: COND_TRUE = FLAGS_IN[FLG_V];
      COND_VC: COND_TRUE = !FLAGS_IN[FLG_V];
      COND_HI: COND_TRUE = FLAGS_IN[FLG_C] && !FLAGS_IN[FLG_Z];
      COND_LS: COND_TRUE = !FLAGS_IN[FLG_C] || FLAGS_IN[FLG_Z];
      COND_GE: COND_TRUE = (FLAGS_IN[FLG_N] == FLAGS_IN[FLG_V]);
      COND_LT: COND_TRUE = (FLAGS_IN[FLG_N] != FLAGS_IN[FLG_V]);
      COND_GT: COND_TRUE = !FLAGS_IN[FLG_Z] && (FLAGS_IN[FLG_N] == FLAGS_IN[FLG_V]);
      COND_LE: COND_TRUE = FLAGS_IN[FLG_Z] || (FLAGS_IN[FLG_N] != FLAGS_IN[FLG_V]);
      default: COND_TRUE = 1'b1;
    endcase
  end

  reg32_en u_result_reg (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_en    (LD),
    .i_d     (w_t),
    .o_q     (REG_Q)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] A;
  logic [31:0] B;
  logic        CIN;
  logic [4:0]  OP;
  logic [3:0]  FLAGS_IN;
  logic [3:0]  COND;
  logic        LD;
  logic [31:0] ALU_OUT;
  logic [3:0]  FLAGS;
  logic        COND_TRUE;
  logic [31:0] REG_Q;

  int n_total = 0;
  int n_pass  = 0;

  alu_exec_unit dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .OP        (OP),
    .FLAGS_IN  (FLAGS_IN),
    .COND      (COND),
    .LD        (LD),
    .ALU_OUT   (ALU_OUT),
    .FLAGS     (FLAGS),
    .COND_TRUE (COND_TRUE),
    .REG_Q     (REG_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive ALU inputs just after a falling edge and let them settle
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [3:0] fl);
    @(negedge CLK);
    OP = op; A = a; B = b; CIN = cin; FLAGS_IN = fl;
    #1;
  endtask

  initial begin
    RESET = 1'b0; A = '0; B = '0; CIN = 1'b0; OP = 5'd0;
    FLAGS_IN = 4'b0000; COND = 4'd0; LD = 1'b0;
    #1;
    chk("reset_regq", REG_Q, 32'h0000_0000);

    @(negedge CLK);
    RESET = 1'b1;

    // ADD wrap to zero: C=1 Z=1
    drive(5'd4, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'b0000);
    chk("add_t", ALU_OUT, 32'h0);
    chk("add_flags", {28'h0, FLAGS}, 32'hC);

    // SUB signed overflow
    drive(5'd2, 32'h8000_0000, 32'h1, 1'b0, 4'b0000);
    chk("sub_t", ALU_OUT, 32'h7FFF_FFFF);
    chk("sub_flags", {28'h0, FLAGS}, 32'hA);

    // CMP 5,7 borrows: C=0 N=1
    drive(5'd10, 32'd5, 32'd7, 1'b1, 4'b1110);
    chk("cmp_t", ALU_OUT, 32'hFFFF_FFFE);
    chk("cmp_flags", {28'h0, FLAGS}, 32'h1);

    // RSB 3-1
    drive(5'd3, 32'd1, 32'd3, 1'b0, 4'b0000);
    chk("rsb_t", ALU_OUT, 32'd2);
    chk("rsb_flags", {28'h0, FLAGS}, 32'h8);

    // ADC 1+1+1
    drive(5'd5, 32'd1, 32'd1, 1'b1, 4'b1000);
    chk("adc_t", ALU_OUT, 32'd3);
    chk("adc_flags", {28'h0, FLAGS}, 32'h0);

    // SBC 5-2-1 with CIN=0
    drive(5'd6, 32'd5, 32'd2, 1'b0, 4'b0000);
    chk("sbc_t", ALU_OUT, 32'd2);
    chk("sbc_flags", {28'h0, FLAGS}, 32'h8);

    // MVN: C from CIN, V kept from FLAGS_IN
    drive(5'd15, 32'h1234, 32'h0, 1'b1, 4'b0010);
    chk("mvn_t", ALU_OUT, 32'hFFFF_FFFF);
    chk("mvn_flags", {28'h0, FLAGS}, 32'hB);

    // BIC
    drive(5'd14, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 4'b0000);
    chk("bic_t", ALU_OUT, 32'hF000_F000);
    chk("bic_flags", {28'h0, FLAGS}, 32'h1);

    // Offset down: flags pass through
    drive(5'd17, 32'h100, 32'd4, 1'b0, 4'b0101);
    chk("subab_t", ALU_OUT, 32'h0000_00FC);
    chk("subab_flags", {28'h0, FLAGS}, 32'h5);

    // Decrement by 4 wraps
    drive(5'd22, 32'h0, 32'h2, 1'b1, 4'b1010);
    chk("decb4_t", ALU_OUT, 32'hFFFF_FFFE);
    chk("decb4_flags", {28'h0, FLAGS}, 32'hA);

    // Increment A by 4
    drive(5'd23, 32'h1000, 32'h0, 1'b0, 4'b0000);
    chk("inca4_t", ALU_OUT, 32'h1004);

    // Unused opcode gives zero, flags pass through
    drive(5'd27, 32'hDEAD_BEEF, 32'h1, 1'b1, 4'b0011);
    chk("op27_t", ALU_OUT, 32'h0);
    chk("op27_flags", {28'h0, FLAGS}, 32'h3);

    // Condition tester
    drive(5'd0, 32'h0, 32'h0, 1'b0, 4'b0100);
    COND = 4'd0; #1;
    chk("cond_eq", {31'h0, COND_TRUE}, 32'd1);
    COND = 4'd1; #1;
    chk("cond_ne", {31'h0, COND_TRUE}, 32'd0);
    FLAGS_IN = 4'b0001;
    COND = 4'd10; #1;
    chk("cond_ge", {31'h0, COND_TRUE}, 32'd0);
    COND = 4'd11; #1;
    chk("cond_lt", {31'h0, COND_TRUE}, 32'd1);
    COND = 4'd13; #1;
    chk("cond_le", {31'h0, COND_TRUE}, 32'd1);
    FLAGS_IN = 4'b1000;
    COND = 4'd8; #1;
    chk("cond_hi", {31'h0, COND_TRUE}, 32'd1);
    COND = 4'd9; #1;
    chk("cond_ls", {31'h0, COND_TRUE}, 32'd0);
    FLAGS_IN = 4'b0011;
    COND = 4'd12; #1;
    chk("cond_gt", {31'h0, COND_TRUE}, 32'd1);
    for (int f = 0; f < 16; f++) begin
      FLAGS_IN = f[3:0];
      COND = 4'd14; #1;
      chk("cond_al", {31'h0, COND_TRUE}, 32'd1);
      COND = 4'd15; #1;
      chk("cond_15", {31'h0, COND_TRUE}, 32'd1);
    end

    // Register load, then hold
    chk("regq_still_zero", REG_Q, 32'h0);
    drive(5'd13, 32'h0, 32'h1234, 1'b0, 4'b0000);
    LD = 1'b1; #1;
    chk("regq_before_edge", REG_Q, 32'h0);
    @(posedge CLK); #1;
    chk("regq_load", REG_Q, 32'h1234);
    @(negedge CLK);
    LD = 1'b0; B = 32'h5678;
    @(posedge CLK); #1;
    chk("regq_hold", REG_Q, 32'h1234);

    // Mid-cycle reset with LD=1
    @(negedge CLK);
    LD = 1'b1; B = 32'h9999;
    #2 RESET = 1'b0;
    #1;
    chk("regq_async_clear", REG_Q, 32'h0);
    chk("alu_in_reset", ALU_OUT, 32'h9999);
    @(posedge CLK); #1;
    chk("regq_reset_over_ld", REG_Q, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("regq_after_release", REG_Q, 32'h0);
    @(posedge CLK); #1;
    chk("regq_first_load", REG_Q, 32'h9999);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
